// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: main control FSM of the multi-cycle RV32I core.
// Sequences fetch/decode/exec/mem/wb and owns the shared memory port.
module rv_multicycle_ctrl #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ir,
  input  logic             br_cond,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret,
  output logic             trap,
  output logic [1:0]       trap_cause
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] PC_4   = 2'b00;
  localparam logic [1:0] PC_IMM = 2'b01;
  localparam logic [1:0] PC_ALU = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic [1:0] CAUSE_ILL = 2'b01;
  localparam logic [1:0] CAUSE_TO  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_R,
    C_I,
    C_LOAD,
    C_STORE,
    C_BR,
    C_JAL,
    C_JALR,
    C_LUI,
    C_AUIPC,
    C_BAD
  } cls_t;

  state_t         state;
  cls_t           cls;
  logic [TW-1:0]  tcnt;
  logic [1:0]     cause;
  logic           stall;
  logic           to_hit;
  logic           unused_ir;

  assign unused_ir  = ^ir[31:7];
  assign trap_cause = cause;

  always_comb begin
    cls = C_BAD;
    unique case (ir[6:0])
      OP_R:     cls = C_R;
      OP_I:     cls = C_I;
      OP_LOAD:  cls = C_LOAD;
      OP_STORE: cls = C_STORE;
      OP_BR:    cls = C_BR;
      OP_JAL:   cls = C_JAL;
      OP_JALR:  cls = C_JALR;
      OP_LUI:   cls = C_LUI;
      OP_AUIPC: cls = C_AUIPC;
      default:  cls = C_BAD;
    endcase
  end

  // A ready that lands on the last allowed cycle still completes.
  assign stall  = mem_req & ~mem_ready;
  assign to_hit = stall & (tcnt == TO_LAST);

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    mdr_we       = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_4;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = ALU_ADD;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    instr_done   = 1'b0;
    trap         = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      S_EXEC: begin
        unique case (cls)
          C_R: alu_op = ALU_FN;
          C_I: begin
            alu_src_b = 1'b1;
            alu_op    = ALU_FN;
          end
          C_LOAD, C_STORE, C_JALR: alu_src_b = 1'b1;
          C_AUIPC: begin
            alu_src_a = 1'b1;
            alu_src_b = 1'b1;
          end
          C_BR: begin
            alu_op     = ALU_SUB;
            pc_we      = 1'b1;
            pc_sel     = br_cond ? PC_IMM : PC_4;
            instr_done = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls == C_STORE);
        if (cls == C_LOAD) begin
          mdr_we = mem_ready;
        end else if (mem_ready) begin
          pc_we      = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        pc_we      = 1'b1;
        instr_done = 1'b1;
        unique case (cls)
          C_LOAD: wb_sel = WB_MDR;
          C_LUI:  wb_sel = WB_IMM;
          C_JAL: begin
            wb_sel = WB_PC4;
            pc_sel = PC_IMM;
          end
          C_JALR: begin
            wb_sel = WB_PC4;
            pc_sel = PC_ALU;
          end
          default: ;
        endcase
      end
      S_TRAP: trap = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      instret <= '0;
      cause   <= '0;
      tcnt    <= '0;
    end else begin
      if (instr_done)
        instret <= instret + CNT_W'(1);
      tcnt <= stall ? tcnt + TW'(1) : '0;
      unique case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (mem_ready) begin
            state <= S_DECODE;
          end else if (to_hit) begin
            state <= S_TRAP;
            cause <= CAUSE_TO;
          end
        end
        S_DECODE: begin
          if (cls == C_BAD) begin
            state <= S_TRAP;
            cause <= CAUSE_ILL;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          unique case (cls)
            C_BR:            state <= S_FETCH;
            C_LOAD, C_STORE: state <= S_MEM;
            default:         state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            state <= (cls == C_LOAD) ? S_WB : S_FETCH;
          end else if (to_hit) begin
            state <= S_TRAP;
            cause <= CAUSE_TO;
          end
        end
        S_WB:    state <= S_FETCH;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb_rv_multicycle_ctrl: directed bench; expected traces are built per
// instruction from its class, then compared every cycle.
module tb_rv_multicycle_ctrl;
  localparam int TO = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   ir;
  logic          br_cond;
  logic          mem_ready;
  logic          mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we;
  logic [1:0]    pc_sel, alu_op, wb_sel, trap_cause;
  logic          alu_src_a, alu_src_b, reg_we, instr_done, trap;
  logic [CW-1:0] instret;

  always #5 clk = ~clk;

  rv_multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ir(ir), .br_cond(br_cond),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .mdr_we(mdr_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we),
    .wb_sel(wb_sel), .instr_done(instr_done), .instret(instret),
    .trap(trap), .trap_cause(trap_cause)
  );

  typedef struct packed {
    logic          mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we;
    logic [1:0]    pc_sel;
    logic          alu_src_a, alu_src_b;
    logic [1:0]    alu_op;
    logic          reg_we;
    logic [1:0]    wb_sel;
    logic          instr_done, trap;
    logic [1:0]    trap_cause;
    logic [CW-1:0] instret;
  } vec_t;

  typedef struct {
    bit    chk;
    vec_t  v;
    string tag;
  } exp_t;

  typedef enum {K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_LUI,
                K_AUIPC, K_BAD} kind_t;

  exp_t  q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    model_cnt = 0;
  int    done_seen = 0;
  string cur = "init";
  vec_t  act;

  assign act = {mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we,
                pc_sel, alu_src_a, alu_src_b, alu_op, reg_we, wb_sel,
                instr_done, trap, trap_cause, instret};

  always @(negedge clk) begin
    exp_t e;
    if (instr_done === 1'b1) done_seen++;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) begin
        vectors++;
        if (act !== e.v) begin
          miscompares++;
          $display("FAIL %s: got %b want %b", e.tag, act, e.v);
        end
      end
    end
  end

  function automatic kind_t kind(input logic [31:0] i);
    case (i[6:0])
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return K_LD;
      7'b0100011: return K_ST;
      7'b1100011: return K_BR;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      default:    return K_BAD;
    endcase
  endfunction

  task automatic step(input logic r, input logic rdy, input bit chk,
                      input vec_t v);
    exp_t e;
    rst       = r;
    mem_ready = rdy;
    e.chk = chk;
    e.v   = v;
    e.v.instret = CW'(model_cnt);
    e.tag = cur;
    q.push_back(e);
    if (v.instr_done) model_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic do_reset();
    vec_t v;
    v = '0;
    cur = "reset";
    step(1'b1, 1'b0, 1'b0, v);
    model_cnt = 0;
    step(1'b1, 1'b1, 1'b1, v);
    cur = "idle";
    step(1'b0, 1'b1, 1'b1, v);
  endtask

  task automatic hold_trap(input logic [1:0] c);
    vec_t v;
    v = '0;
    v.trap = 1'b1;
    v.trap_cause = c;
    for (int i = 0; i < 4; i++) begin
      ir = i[0] ? 32'h0000_0013 : 32'h0000_A103;
      step(1'b0, i[0], 1'b1, v);
    end
  endtask

  task automatic run(input string name, input logic [31:0] instr,
                     input logic bc, input int fw, input int mw,
                     input bit abort_mem);
    kind_t k;
    vec_t  v;
    k = kind(instr);
    cur = name;
    ir = instr;
    br_cond = bc;
    v = '0;
    v.mem_req = 1'b1;
    for (int i = 0; i < fw && i < TO; i++) step(1'b0, 1'b0, 1'b1, v);
    if (fw >= TO) begin
      hold_trap(2'b10);
      return;
    end
    v.ir_we = 1'b1;
    step(1'b0, 1'b1, 1'b1, v);
    v = '0;
    step(1'b0, 1'b1, 1'b1, v);
    if (k == K_BAD) begin
      hold_trap(2'b01);
      return;
    end
    case (k)
      K_R: v.alu_op = 2'd2;
      K_I: begin
        v.alu_src_b = 1'b1;
        v.alu_op = 2'd2;
      end
      K_LD, K_ST, K_JALR: v.alu_src_b = 1'b1;
      K_AUIPC: begin
        v.alu_src_a = 1'b1;
        v.alu_src_b = 1'b1;
      end
      K_BR: begin
        v.alu_op = 2'd1;
        v.pc_we = 1'b1;
        v.pc_sel = bc ? 2'd1 : 2'd0;
        v.instr_done = 1'b1;
      end
      default: ;
    endcase
    step(1'b0, 1'b1, 1'b1, v);
    if (k == K_BR) return;
    if (k == K_LD || k == K_ST) begin
      v = '0;
      v.mem_req = 1'b1;
      v.mem_addr_sel = 1'b1;
      v.mem_we = (k == K_ST);
      for (int i = 0; i < mw && i < TO; i++) step(1'b0, 1'b0, 1'b1, v);
      if (abort_mem) return;
      if (mw >= TO) begin
        hold_trap(2'b10);
        return;
      end
      if (k == K_LD) begin
        v.mdr_we = 1'b1;
      end else begin
        v.pc_we = 1'b1;
        v.instr_done = 1'b1;
      end
      step(1'b0, 1'b1, 1'b1, v);
      if (k == K_ST) return;
    end
    v = '0;
    v.reg_we = 1'b1;
    v.pc_we = 1'b1;
    v.instr_done = 1'b1;
    case (k)
      K_LD:  v.wb_sel = 2'd1;
      K_LUI: v.wb_sel = 2'd3;
      K_JAL: begin
        v.wb_sel = 2'd2;
        v.pc_sel = 2'd1;
      end
      K_JALR: begin
        v.wb_sel = 2'd2;
        v.pc_sel = 2'd2;
      end
      default: ;
    endcase
    step(1'b0, 1'b1, 1'b1, v);
  endtask

  initial begin
    rst = 1'b1;
    ir = 32'h0;
    br_cond = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    run("addi", 32'h0050_0093, 1'b0, 0, 0, 1'b0);
    pin("instret_after_addi", 32'(instret), 32'd1);
    run("lw_wait3", 32'h0000_A103, 1'b0, 0, 3, 1'b0);
    pin("done_after_lw", done_seen, 32'd2);
    run("beq_taken", 32'h0020_8463, 1'b1, 0, 0, 1'b0);
    run("beq_not", 32'h0020_8463, 1'b0, 0, 0, 1'b0);
    run("sw", 32'h0020_A223, 1'b0, 0, 1, 1'b0);
    run("add", 32'h0020_81B3, 1'b0, 0, 0, 1'b0);
    run("lui", 32'h1234_50B7, 1'b0, 0, 0, 1'b0);
    run("auipc", 32'h0000_0097, 1'b0, 0, 0, 1'b0);
    run("jalr", 32'h0000_80E7, 1'b0, 0, 0, 1'b0);
    run("jal", 32'h0080_00EF, 1'b0, 0, 0, 1'b0);
    run("fetch_late", 32'h0050_0093, 1'b0, 7, 0, 1'b0);
    for (int i = 0; i < 6; i++)
      run("lui_wrap", 32'h0000_10B7, 1'b0, 0, 0, 1'b0);
    pin("instret_wrap", 32'(instret), 32'd1);
    pin("done_total", done_seen, 32'd17);
    run("illegal", 32'hFFFF_FFFF, 1'b0, 0, 0, 1'b0);
    pin("cause_illegal", 32'(trap_cause), 32'd1);
    pin("done_no_retire", done_seen, 32'd17);
    do_reset();
    run("fetch_timeout", 32'h0050_0093, 1'b0, 8, 0, 1'b0);
    pin("cause_timeout", 32'(trap_cause), 32'd2);
    do_reset();
    run("sw_abort", 32'h0020_A223, 1'b0, 0, 2, 1'b1);
    do_reset();
    run("addi_resume", 32'h0050_0093, 1'b0, 0, 0, 1'b0);
    run("lw_split", 32'h0000_A103, 1'b0, 5, 5, 1'b0);
    pin("instret_resume", 32'(instret), 32'd2);
    run("lw_mem_timeout", 32'h0000_A103, 1'b0, 0, 8, 1'b0);
    pin("cause_mem_timeout", 32'(trap_cause), 32'd2);
    pin("done_final", done_seen, 32'd19);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
